// File: rtl/gpio_step_sequencer.sv
// gpio_step_sequencer
//
// Drives the 32-bit GPIO control/status word of the HLS model wrapper
// directly from hardware. It runs one host command at a time:
//   op 0 = BRAM reset, 1 = param load, 2 = train step (fw then bw), 3 = grad extract.
// For each command it pulses the start/complete/reset control bits, waits on
// the finish/idle/busy status bits and pulses done when the command is finished.
//
// Ports
//   ap_clk        sole clock, rising edge
//   ap_rst        asynchronous active-high reset
//   cmd_valid     command request from the host
//   cmd_ready     high only while idle; accept = cmd_valid && cmd_ready
//   cmd_op        2-bit opcode (see above)
//   cmd_cache_en  latched on accept, driven on gpio_o[24] until the next accept
//   cmd_bram_sel  latched on accept, driven on gpio_o[25] until the next accept
//   gpio_o        registered control word
//   gpio_i        status word from the wrapper
//   done          one-cycle completion pulse
//   err           sticky timeout flag, cleared on the next accept
//
// Build option
//   SEQ_TIMEOUT_EN  when defined, every wait state aborts after TIMEOUT_CYCLES
//                   cycles (control bits drop, err set, done pulses). When
//                   undefined, waits are unbounded and err stays 0.
module gpio_step_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1 << 20,
    parameter int unsigned RESET_PULSE    = 4
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_cache_en,
    input  logic        cmd_bram_sel,
    output logic [31:0] gpio_o,
    input  logic [31:0] gpio_i,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_PULSE,
        S_RST_WAIT,
        S_RUN_START,
        S_RUN_COMPLETE,
        S_RUN_IDLE_WAIT,
        S_DONE
    } state_t;

    // Unit encoding chosen so the start bit sits at 4*unit and the finish
    // status bit at 29-4*unit.
    localparam logic [1:0] U_FW    = 2'd0;
    localparam logic [1:0] U_BW    = 2'd1;
    localparam logic [1:0] U_PARAM = 2'd2;
    localparam logic [1:0] U_GRAD  = 2'd3;

    localparam int PW = (RESET_PULSE > 1) ? $clog2(RESET_PULSE) : 1;

    state_t          state_q, state_d;
    logic [1:0]      unit_q, unit_d;
    logic            cache_en_q, cache_en_d;
    logic            bram_sel_q, bram_sel_d;
    logic [PW-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic [31:0]     gpio_q, gpio_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [3:0]      unit_fin;
    logic [3:0]      unit_idle;
    logic            cur_fin;
    logic            cur_idle;
    logic            busy_clear;
    logic            expired;

    // Per-unit finish/idle status taps.
    for (genvar gi = 0; gi < 4; gi++) begin : g_status
        assign unit_fin[gi]  = gpio_i[29 - 4*gi];
        assign unit_idle[gi] = gpio_i[28 - 4*gi];
    end

    assign cur_fin    = unit_fin[unit_q];
    assign cur_idle   = unit_idle[unit_q];
    assign busy_clear = ~gpio_i[14] & ~gpio_i[10];

    // Echo bits 15/11 and the constant-1 bits carry no information here.
    logic unused_status;
    assign unused_status = ^{gpio_i[31:30], gpio_i[27:26], gpio_i[23:22],
                             gpio_i[19:18], gpio_i[15], gpio_i[13:11], gpio_i[9:0]};

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;

    // Counter holds the number of cycles already spent in the current state
    // minus one, so expiry fires on the TIMEOUT_CYCLES-th cycle of the wait.
    assign expired    = (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign wait_cnt_d = (state_d == state_q) ? wait_cnt_q + 1'b1 : '0;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES[0];
    assign expired        = 1'b0;
`endif

    // Next-state logic. Handshakes are tested before expiry so a response
    // arriving on the last counted cycle still wins.
    always_comb begin
        state_d     = state_q;
        unit_d      = unit_q;
        cache_en_d  = cache_en_q;
        bram_sel_d  = bram_sel_q;
        pulse_cnt_d = pulse_cnt_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    cache_en_d  = cmd_cache_en;
                    bram_sel_d  = cmd_bram_sel;
                    err_d       = 1'b0;
                    pulse_cnt_d = '0;
                    case (cmd_op)
                        2'd0:    state_d = S_RST_PULSE;
                        2'd1:    begin unit_d = U_PARAM; state_d = S_RUN_START; end
                        2'd2:    begin unit_d = U_FW;    state_d = S_RUN_START; end
                        default: begin unit_d = U_GRAD;  state_d = S_RUN_START; end
                    endcase
                end
            end
            S_RST_PULSE: begin
                if (pulse_cnt_q == PW'(RESET_PULSE - 1)) begin
                    state_d = S_RST_WAIT;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 1'b1;
                end
            end
            S_RST_WAIT: begin
                if (busy_clear) begin
                    state_d = S_DONE;
                end else if (expired) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_RUN_START: begin
                if (cur_fin) begin
                    state_d = S_RUN_COMPLETE;
                end else if (expired) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_RUN_COMPLETE: begin
                state_d = S_RUN_IDLE_WAIT;
            end
            S_RUN_IDLE_WAIT: begin
                if (cur_idle) begin
                    if (unit_q == U_FW) begin
                        unit_d  = U_BW;
                        state_d = S_RUN_START;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (expired) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output word is decoded from the next state so every control bit
    // leaves a flop and lines up with the state it belongs to.
    always_comb begin
        gpio_d     = '0;
        gpio_d[24] = cache_en_d;
        gpio_d[25] = bram_sel_d;
        case (state_d)
            S_RST_PULSE: begin
                gpio_d[16] = 1'b1;
                gpio_d[20] = 1'b1;
            end
            S_RUN_START:    gpio_d[{1'b0, unit_d, 2'b00}] = 1'b1;
            S_RUN_COMPLETE: gpio_d[{1'b0, unit_d, 2'b01}] = 1'b1;
            default: ;
        endcase
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= S_IDLE;
            unit_q      <= U_FW;
            cache_en_q  <= 1'b0;
            bram_sel_q  <= 1'b0;
            pulse_cnt_q <= '0;
            gpio_q      <= '0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            unit_q      <= unit_d;
            cache_en_q  <= cache_en_d;
            bram_sel_q  <= bram_sel_d;
            pulse_cnt_q <= pulse_cnt_d;
            gpio_q      <= gpio_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign gpio_o    = gpio_q;
    assign cmd_ready = ready_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_gpio_step_sequencer.sv
// Directed bench for gpio_step_sequencer. A small responder emulates the
// HLS wrapper status bits; a negedge monitor counts per-bit high cycles,
// the cycle index of done relative to the accept, and protocol violations.
module tb_gpio_step_sequencer;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic        cmd_cache_en = 1'b0;
    logic        cmd_bram_sel = 1'b0;
    logic [31:0] gpio_o;
    logic [31:0] gpio_i;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 ap_clk = ~ap_clk;

    gpio_step_sequencer #(
        .TIMEOUT_CYCLES (16),
        .RESET_PULSE    (4)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_cache_en (cmd_cache_en),
        .cmd_bram_sel (cmd_bram_sel),
        .gpio_o       (gpio_o),
        .gpio_i       (gpio_i),
        .done         (done),
        .err          (err)
    );

    // ---------------- responder ----------------
    int fin_delay  = 1;   // 0 = never raise finish
    int idle_delay = 0;
    int busy_hold  = 0;
    int run_cnt[4];
    int icnt[4];
    int bcnt = 0;
    bit fin[4];
    bit idl[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    bit busy = 1'b0;

    always @(negedge ap_clk) begin
        if (ap_rst) begin
            for (int u = 0; u < 4; u++) begin
                run_cnt[u] = 0; icnt[u] = 0; fin[u] = 1'b0; idl[u] = 1'b1;
            end
            busy = 1'b0; bcnt = 0;
        end else begin
            for (int u = 0; u < 4; u++) begin
                if (gpio_o[4*u]) begin
                    idl[u] = 1'b0;
                    run_cnt[u]++;
                    if (fin_delay != 0 && run_cnt[u] >= fin_delay) fin[u] = 1'b1;
                end else if (gpio_o[4*u+1]) begin
                    fin[u] = 1'b0;
                    run_cnt[u] = 0;
                    if (idle_delay == 0) idl[u] = 1'b1;
                    else icnt[u] = idle_delay;
                end else if (icnt[u] > 0) begin
                    icnt[u]--;
                    if (icnt[u] == 0) idl[u] = 1'b1;
                end
            end
            if (gpio_o[16]) begin
                busy = 1'b1;
                bcnt = busy_hold;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) busy = 1'b0;
            end else begin
                busy = 1'b0;
            end
        end
    end

    always_comb begin
        gpio_i     = 32'h8000_0008;        // constant-1 bits the DUT must ignore
        gpio_i[15] = gpio_o[16];           // echo bits
        gpio_i[11] = gpio_o[20];
        gpio_i[14] = busy;
        gpio_i[10] = busy;
        for (int u = 0; u < 4; u++) begin
            gpio_i[29 - 4*u] = fin[u];
            gpio_i[28 - 4*u] = idl[u];
        end
    end

    // ---------------- monitor ----------------
    int         k_cnt = 0;
    int         done_k = 0;
    int         done_cnt = 0;
    int         hi_cnt[32];
    int         first_hi[32];
    bit         overlap = 1'b0;
    bit         stray = 1'b0;
    bit         side_bad = 1'b0;
    logic [1:0] side_exp = 2'b00;

    always @(negedge ap_clk) begin
        if (ap_rst) side_exp = 2'b00;
        k_cnt++;
        if (done) begin
            done_cnt++;
            if (done_cnt == 1) done_k = k_cnt;
        end
        for (int b = 0; b < 32; b++) begin
            if (gpio_o[b]) begin
                hi_cnt[b]++;
                if (first_hi[b] == 0) first_hi[b] = k_cnt;
            end
        end
        if ($countones({gpio_o[0], gpio_o[4], gpio_o[8], gpio_o[12]}) > 1) overlap = 1'b1;
        if ((gpio_o & ~32'h0311_3333) != 32'h0) stray = 1'b1;
        if (gpio_o[25:24] !== side_exp) side_bad = 1'b1;
        // accept happens on the coming edge: restart bookkeeping
        if (cmd_valid && cmd_ready) begin
            k_cnt = 0; done_k = 0; done_cnt = 0;
            overlap = 1'b0; stray = 1'b0; side_bad = 1'b0;
            side_exp = {cmd_bram_sel, cmd_cache_en};
            for (int b = 0; b < 32; b++) begin
                hi_cnt[b] = 0; first_hi[b] = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic ce, input logic bs);
        @(posedge ap_clk); #1;
        cmd_op = op; cmd_cache_en = ce; cmd_bram_sel = bs; cmd_valid = 1'b1;
        @(posedge ap_clk); #1;
        cmd_valid = 1'b0;
        $display("cmd op=%0d cache_en=%0d bram_sel=%0d issued at %0t", op, ce, bs, $time);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin
            @(negedge ap_clk); #1;
            n++;
        end
        repeat (3) @(negedge ap_clk);
        #1;
        check_eq({tag, " done_cnt"}, done_cnt, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // reset values
        #1 ap_rst = 1'b1;
        #1;
        check_eq("rst gpio_o", gpio_o, 32'h0);
        check_eq("rst cmd_ready", cmd_ready, 0);
        check_eq("rst done", done, 0);
        check_eq("rst err", err, 0);
        @(posedge ap_clk); @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        @(posedge ap_clk); #1;
        check_eq("post-rst cmd_ready", cmd_ready, 1);

        // op1: finish 5 cycles after start, idle 2 after complete
        fin_delay = 5; idle_delay = 2;
        issue_cmd(2'd1, 1'b0, 1'b0);
        wait_done("op1", 100);
        check_eq("op1 param start cycles", hi_cnt[8], 5);
        check_eq("op1 param complete cycles", hi_cnt[9], 1);
        check_eq("op1 done cycle", done_k, 9);
        check_eq("op1 err", err, 0);
        check_eq("op1 stray bits", stray, 0);

        // op1 minimum latency
        fin_delay = 1; idle_delay = 0;
        issue_cmd(2'd1, 1'b0, 1'b0);
        wait_done("op1 fast", 100);
        check_eq("op1 fast done cycle", done_k, 4);

        // op2 with cache_en/bram_sel set
        fin_delay = 3; idle_delay = 1;
        issue_cmd(2'd2, 1'b1, 1'b1);
        wait_done("op2", 100);
        check_eq("op2 fw start cycles", hi_cnt[0], 3);
        check_eq("op2 fw complete cycles", hi_cnt[1], 1);
        check_eq("op2 fw complete first", first_hi[1], 4);
        check_eq("op2 bw start cycles", hi_cnt[4], 3);
        check_eq("op2 bw start first", first_hi[4], 6);
        check_eq("op2 bw complete cycles", hi_cnt[5], 1);
        check_eq("op2 done cycle", done_k, 11);
        check_eq("op2 start overlap", overlap, 0);
        check_eq("op2 side bits wrong", side_bad, 0);
        check_eq("op2 side bits after done", gpio_o[25:24], 2'b11);

        // op0: busy held 10 cycles after the pulse
        busy_hold = 10;
        issue_cmd(2'd0, 1'b0, 1'b0);
        wait_done("op0", 100);
        check_eq("op0 param_reset cycles", hi_cnt[16], 4);
        check_eq("op0 grad_reset cycles", hi_cnt[20], 4);
        check_eq("op0 done cycle", done_k, 15);
        check_eq("op0 side bits wrong", side_bad, 0);

        // cmd_valid while busy must be ignored
        fin_delay = 8; idle_delay = 0;
        issue_cmd(2'd1, 1'b0, 1'b0);
        cmd_op = 2'd0; cmd_valid = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1 cmd_valid = 1'b0;
        wait_done("busy-ignore", 100);
        check_eq("busy-ignore done cycle", done_k, 11);
        check_eq("busy-ignore reset bits", hi_cnt[16], 0);

`ifdef SEQ_TIMEOUT_EN
        // op3 with grad finish never raised
        fin_delay = 0;
        issue_cmd(2'd3, 1'b0, 1'b0);
        wait_done("timeout", 100);
        check_eq("timeout grad start cycles", hi_cnt[12], 16);
        check_eq("timeout grad complete cycles", hi_cnt[13], 0);
        check_eq("timeout done cycle", done_k, 17);
        check_eq("timeout err set", err, 1);
        fin_delay = 1; idle_delay = 0;
        issue_cmd(2'd1, 1'b0, 1'b0);
        check_eq("timeout err cleared on accept", err, 0);
        wait_done("after timeout", 100);
        check_eq("after timeout done cycle", done_k, 4);
`endif

        // async reset during RUN_START of op2
        fin_delay = 20; idle_delay = 0;
        issue_cmd(2'd2, 1'b1, 1'b0);
        repeat (3) @(negedge ap_clk);
        #1 ap_rst = 1'b1;
        #1;
        check_eq("midrst gpio_o", gpio_o, 32'h0);
        check_eq("midrst cmd_ready", cmd_ready, 0);
        check_eq("midrst done", done, 0);
        @(posedge ap_clk); @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        @(posedge ap_clk); #1;
        check_eq("midrst cmd_ready after release", cmd_ready, 1);
        fin_delay = 2; idle_delay = 0;
        issue_cmd(2'd1, 1'b0, 1'b0);
        wait_done("post-midrst op1", 100);
        check_eq("post-midrst done cycle", done_k, 5);
        check_eq("post-midrst param complete", hi_cnt[9], 1);
        check_eq("post-midrst err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_step_sequencer.md
# gpio_step_sequencer

Hardware-side initiator for the 32-bit GPIO control/status word used by the HLS model wrapper. It replaces the PS software driver. It accepts one command at a time: BRAM reset, param load, train step (forward then backward), or grad extract. For each command it drives the start/complete/reset control bits, decodes the finish/idle/busy status bits, and signals completion. It sits between a host command port and the GPIO word connection block.

## Interface
- `TIMEOUT_CYCLES`, 2^20: maximum cycles spent in any single wait state before abort (only with timeout feature).
- `RESET_PULSE`, 4: cycles that `param_reset`/`grad_reset` are held high.
- `ap_clk` in 1: sole clock, rising edge.
- `ap_rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE; a command is accepted when valid && ready.
- `cmd_op` in 2: 0 = reset BRAMs, 1 = param load, 2 = train step, 3 = grad extract.
- `cmd_cache_en` in 1, `cmd_bram_sel` in 1: latched on accept.
- `gpio_o` out 32: control word; all bits are registered.
- `gpio_i` in 32: status word.
- `done` out 1: one-cycle pulse at command completion.
- `err` out 1: sticky timeout flag, cleared on next accept.

## Operation
- Control bit map in `gpio_o`:
  - fw start/complete = 0/1
  - bw start/complete = 4/5
  - param start/complete = 8/9
  - grad start/complete = 12/13
  - param_reset = 16, grad_reset = 20
  - cache_en = 24, bram_sel = 25
  - all other bits 0.
- Status bit map in `gpio_i` (finish/idle):
  - fw = 29/28
  - bw = 25/24
  - param = 21/20
  - grad = 17/16
  - param_reset_busy = 14, grad_reset_busy = 10
  - bits 15 and 11 echo the reset controls and are ignored
  - constant-1 bits are ignored.
- Phase list per op:
  - op0: RST only.
  - op1: param.
  - op2: fw, then bw.
  - op3: grad.
- States and transitions:
  - IDLE → (op0) RST_PULSE or (else) RUN_START.
  - RST_PULSE: bits 16 and 20 both high for `RESET_PULSE` cycles → RST_WAIT.
  - RST_WAIT: wait until both busy bits are 0 → DONE.
  - RUN_START: start bit of the current unit high; hold until its finish bit = 1 → RUN_COMPLETE.
  - RUN_COMPLETE: start 0, complete bit high for exactly one cycle → RUN_IDLE_WAIT.
  - RUN_IDLE_WAIT: wait until idle bit = 1, then → RUN_START for the next phase, or → DONE if the list is exhausted.
  - DONE: `done` = 1 for one cycle → IDLE.
- cache_en/bram_sel hold their latched values from accept until the next accept; they are unaffected by abort.
- `cmd_valid` outside IDLE is ignored (no queueing).

## Timing
- Reset: `gpio_o` = 0, `cmd_ready` = 0 while `ap_rst` is high, `done` = 0, `err` = 0, state = IDLE, counters cleared. `cmd_ready` = 1 in the first cycle after reset release.
- Reset mid-operation: all outputs clear asynchronously with no complete pulse; the HLS side is left to its own reset.
- Latency:
  - accept at edge N → start bit visible at N+1.
  - finish sampled at edge M → complete high during M+1 only.
  - `done` asserts in the cycle after the final idle (or busy-clear) is sampled.
- Minimum op1 latency with an immediate finish/idle response: 4 cycles from accept to `done`.
- Status inputs are sampled registered-state-only, with no combinational path from `gpio_i` to `gpio_o`.
- Phase transition fw→bw: fw idle sampled → bw start asserted the next cycle; fw and bw start are never high together.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - Each wait state (RUN_START, RUN_IDLE_WAIT, RST_WAIT) runs a counter, cleared on state entry.
  - On reaching `TIMEOUT_CYCLES`: all start/complete/reset bits drop to 0, `err` is set, `done` pulses, state → IDLE.
  - If finish/idle/busy-clear arrives in the same cycle the count expires, the handshake wins and no error is raised.
- `SEQ_TIMEOUT_EN` undefined: no counter and waits are unbounded; `err` is tied to 0.

## Test plan
- op1, responder raises param finish 5 cycles after start and idle 2 cycles after complete → `gpio_o[8]` high exactly 5 cycles, `gpio_o[9]` high for 1 cycle, `done` at the expected cycle, `err` = 0.
- op2 with cmd_cache_en = 1, bram_sel = 1 → `gpio_o[24]` = `gpio_o[25]` = 1 throughout; bits 0/1 sequence, then bits 4/5, never overlapping; one `done` pulse.
- op0, busy bits 14/10 held high 10 cycles after the pulse → bits 16/20 high for 4 cycles; `done` only after both busy bits clear.
- `SEQ_TIMEOUT_EN` with `TIMEOUT_CYCLES` = 16, op3 with grad finish never raised → `gpio_o[12]` drops after 16 cycles, `err` = 1, `done` pulses; the next accept clears `err`.
- `ap_rst` asserted during RUN_START of op2 → `gpio_o` = 0 immediately (asynchronously); after release `cmd_ready` = 1 and a new op1 completes normally.
- `cmd_valid` pulsed while busy → ignored; exactly one `done` per accepted command.
